// File: rtl/norm_pkg.sv
// norm_pkg: shared defaults and row types for the normalizer collector.
package norm_pkg;
  localparam int COL_DEF = 8;
  localparam int W_OUT_DEF = 16;
  typedef logic [W_OUT_DEF-1:0] elem_t;
  typedef elem_t [COL_DEF-1:0] row_t;
  typedef struct packed {
    row_t r1;
    row_t r2;
  } row_pair_t;
endpackage

// File: rtl/norm_row_fifo.sv
// norm_row_fifo: row-pair FIFO with a registered head that holds its last value when empty.
module norm_row_fifo
  import norm_pkg::*;
#(
  parameter int W = $bits(row_pair_t),
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] head_q, head_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d, rem;
  logic do_push, do_pop, we;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
  assign head = head_q;
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    we = do_push & ~flush;
    rem = cnt_q - (AW+1)'(do_pop);
    cnt_d = flush ? '0 : rem + (AW+1)'(do_push);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    // a push into an otherwise empty queue bypasses the memory into the head
    head_d = flush ? head_q : rem != '0 ? mem_q[rd_d] : do_push ? din : head_q;
  end
  always_ff @(posedge clk) if (we) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      head_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/norm_collector.sv
// norm_collector: reassembles serial normalized elements into row pairs and queues them.
// NORM_COLLECT_PERF_EN adds saturating rows_pushed/rows_dropped counters.
module norm_collector
  import norm_pkg::*;
#(
  parameter int COL = COL_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   norm_valid,
  input  logic [W_OUT-1:0]       psum_norm_1,
  input  logic [W_OUT-1:0]       psum_norm_2,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COL*W_OUT-1:0]   m_data_1,
  output logic [COL*W_OUT-1:0]   m_data_2,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
`ifdef NORM_COLLECT_PERF_EN
  ,
  output logic [31:0]            rows_pushed,
  output logic [15:0]            rows_dropped
`endif
);
  localparam int IW = $clog2(COL);
  localparam int RW = COL*W_OUT;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] row1_q, row1_d, row2_q, row2_d;
  logic overflow_q, overflow_d;
  logic accept, done, drop, full, empty;
  logic [2*RW-1:0] head;
  always_comb begin
    accept = norm_valid & ~flush;
    done = accept && idx_q == IW'(COL-1);
    drop = done & full & ~(m_ready & ~empty);
    row1_d = row1_q;
    row2_d = row2_q;
    if (accept) begin
      row1_d[idx_q*W_OUT +: W_OUT] = psum_norm_1;
      row2_d[idx_q*W_OUT +: W_OUT] = psum_norm_2;
    end
    idx_d = flush ? '0 : idx_q + IW'(accept);
    overflow_d = flush ? 1'b0 : overflow_q | drop;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      row1_q <= '0;
      row2_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      row1_q <= row1_d;
      row2_q <= row2_d;
      overflow_q <= overflow_d;
    end
  end
  // the completing element reaches the FIFO through row*_d on the same edge
  norm_row_fifo #(.W(2*RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(done),
    .pop(m_ready),
    .din({row2_d, row1_d}),
    .head(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign m_valid = ~empty;
  assign m_data_1 = head[RW-1:0];
  assign m_data_2 = head[2*RW-1:RW];
  assign overflow = overflow_q;
`ifdef NORM_COLLECT_PERF_EN
  logic [31:0] pushed_q, pushed_d;
  logic [15:0] dropped_q, dropped_d;
  always_comb begin
    pushed_d = flush ? '0 : pushed_q + 32'(done & ~drop & ~&pushed_q);
    dropped_d = flush ? '0 : dropped_q + 16'(drop & ~&dropped_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pushed_q <= '0;
      dropped_q <= '0;
    end else begin
      pushed_q <= pushed_d;
      dropped_q <= dropped_d;
    end
  end
  assign rows_pushed = pushed_q;
  assign rows_dropped = dropped_q;
`endif
endmodule

// File: tb/tb_norm_collector.sv
// tb_norm_collector: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_norm_collector;
  logic clk = 1'b0, reset = 1'b0, norm_valid = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic [15:0] psum_norm_1 = '0, psum_norm_2 = '0;
  logic m_valid, overflow;
  logic [127:0] m_data_1, m_data_2;
  logic [2:0] level;
`ifdef NORM_COLLECT_PERF_EN
  logic [31:0] rows_pushed;
  logic [15:0] rows_dropped;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  norm_collector dut (
    .clk(clk), .reset(reset), .norm_valid(norm_valid),
    .psum_norm_1(psum_norm_1), .psum_norm_2(psum_norm_2), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_1(m_data_1), .m_data_2(m_data_2),
    .overflow(overflow), .level(level)
`ifdef NORM_COLLECT_PERF_EN
    , .rows_pushed(rows_pushed), .rows_dropped(rows_dropped)
`endif
  );

  logic [255:0] q[$];
  logic [15:0] p1[8], p2[8];
  int n = 0, pushed = 0, dropped = 0;
  bit ovf = 0;
  logic [127:0] h1 = '0, h2 = '0;

  task automatic model_clear();
    q.delete();
    n = 0;
    ovf = 0;
    pushed = 0;
    dropped = 0;
  endtask

  task automatic model_step();
    logic [255:0] row;
    bit pop, comp;
    if (flush) model_clear();
    else begin
      pop = q.size() > 0 && m_ready;
      comp = 0;
      if (norm_valid) begin
        p1[n] = psum_norm_1;
        p2[n] = psum_norm_2;
        n++;
        if (n == 8) begin
          comp = 1;
          n = 0;
        end
      end
      if (pop) void'(q.pop_front());
      if (comp) begin
        for (int k = 0; k < 8; k++) begin
          row[k*16 +: 16] = p1[k];
          row[128 + k*16 +: 16] = p2[k];
        end
        if (q.size() < 4) begin
          q.push_back(row);
          pushed++;
        end else begin
          ovf = 1;
          dropped++;
        end
      end
      if (q.size() > 0) begin
        h1 = q[0][127:0];
        h2 = q[0][255:128];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_valid", 128'(m_valid), 128'(q.size() > 0));
    chk("level", 128'(level), 128'(q.size()));
    chk("overflow", 128'(overflow), 128'(ovf));
    chk("m_data_1", m_data_1, h1);
    chk("m_data_2", m_data_2, h2);
`ifdef NORM_COLLECT_PERF_EN
    chk("rows_pushed", 128'(rows_pushed), 128'(pushed));
    chk("rows_dropped", 128'(rows_dropped), 128'(dropped));
`endif
  endtask

  always @(posedge clk) begin
    if (reset) model_step();
    #1;
    compare_all();
  end

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic f);
    @(negedge clk);
    norm_valid = v;
    psum_norm_1 = a;
    psum_norm_2 = b;
    flush = f;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic send_row(input logic [15:0] b1, input logic [15:0] b2, input bit ready_last);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, b1 + 16'(k), b2 + 16'(k), 1'b0);
      if (ready_last) m_ready = (k == 7);
    end
    idle(1);
    if (ready_last) m_ready = 1'b0;
  endtask

  initial begin
    model_clear();
    idle(3);
    reset = 1'b1;
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_data", m_data_1, 128'(0));
    // basic row
    send_row(16'h0000, 16'h0100, 0);
    chk("basic_valid", 128'(m_valid), 128'(1));
    chk("basic_level", 128'(level), 128'(1));
    chk("basic_d1", m_data_1, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("basic_d2", m_data_2, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    chk("pop_level", 128'(level), 128'(0));
    chk("pop_hold", m_data_1, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    // stall mid-row
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h20 + 16'(k), 16'h30 + 16'(k), 1'b0);
    idle(5);
    chk("stall_no_valid", 128'(m_valid), 128'(0));
    for (int k = 3; k < 8; k++) drive(1'b1, 16'h20 + 16'(k), 16'h30 + 16'(k), 1'b0);
    idle(1);
    chk("stall_d1", m_data_1, 128'h0027_0026_0025_0024_0023_0022_0021_0020);
    chk("stall_d2", m_data_2, 128'h0037_0036_0035_0034_0033_0032_0031_0030);
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    // backpressure and overflow
    for (int r = 0; r < 5; r++) send_row(16'((r + 1) * 16'h1000), 16'((r + 1) * 16'h1000 + 16'h800), 0);
    chk("bp_level", 128'(level), 128'(4));
    chk("bp_overflow", 128'(overflow), 128'(1));
    chk("bp_head", 128'(m_data_1[15:0]), 128'(16'h1000));
    m_ready = 1'b1;
    idle(6);
    m_ready = 1'b0;
    chk("drain_level", 128'(level), 128'(0));
    chk("drain_last", 128'(m_data_1[127:112]), 128'(16'h4007));
`ifdef NORM_COLLECT_PERF_EN
    chk("perf_pushed", 128'(rows_pushed), 128'(6));
    chk("perf_dropped", 128'(rows_dropped), 128'(1));
`endif
    // full plus simultaneous pop
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    idle(1);
    chk("flush_ovf", 128'(overflow), 128'(0));
    for (int r = 0; r < 4; r++) send_row(16'h5000 + 16'(r * 256), 16'h6000 + 16'(r * 256), 0);
    send_row(16'h5400, 16'h6400, 1);
    chk("fullpop_level", 128'(level), 128'(4));
    chk("fullpop_ovf", 128'(overflow), 128'(0));
    chk("fullpop_head", 128'(m_data_1[15:0]), 128'(16'h5100));
    // flush with a partial row and two rows queued
    m_ready = 1'b1;
    idle(2);
    m_ready = 1'b0;
    chk("pre_flush_level", 128'(level), 128'(2));
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h7000 + 16'(k), 16'h7800 + 16'(k), 1'b0);
    drive(1'b1, 16'hdead, 16'hbeef, 1'b1);
    idle(1);
    chk("flush_valid", 128'(m_valid), 128'(0));
    chk("flush_level", 128'(level), 128'(0));
    send_row(16'h7100, 16'h7200, 0);
    chk("post_flush_d1", m_data_1, 128'h7107_7106_7105_7104_7103_7102_7101_7100);
    chk("post_flush_d2", m_data_2, 128'h7207_7206_7205_7204_7203_7202_7201_7200);
    // async reset mid-row while m_valid=1
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h9000 + 16'(k), 16'h9800 + 16'(k), 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    norm_valid = 1'b0;
    model_clear();
    h1 = '0;
    h2 = '0;
    #1;
    chk("arst_valid", 128'(m_valid), 128'(0));
    chk("arst_level", 128'(level), 128'(0));
    chk("arst_d1", m_data_1, 128'(0));
    chk("arst_d2", m_data_2, 128'(0));
    chk("arst_ovf", 128'(overflow), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    send_row(16'h0a00, 16'h0b00, 0);
    chk("after_rst_d1", m_data_1, 128'h0a07_0a06_0a05_0a04_0a03_0a02_0a01_0a00);
    chk("after_rst_level", 128'(level), 128'(1));
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/norm_collector.md
Name: norm_collector

Overview:
- Sits downstream of the normalizer in the clk domain and receives its serial normalized output: one element per core per cycle, qualified by norm_valid.
- Reassembles each core's COL serial elements back into a COL-wide row.
- Buffers completed row pairs in a small FIFO and presents them to the writeback/SRAM side with a valid/ready handshake.
- Flags any row lost to FIFO overflow.

Parameters:
- COL, 8, elements per row (lanes); must be a power of 2, at least 2.
- W_OUT, 16, width of each normalized element.
- DEPTH, 4, FIFO depth in row pairs; must be a power of 2, at least 2.

Ports:
- clk  in  1  single clock, shared with the normalizer.
- reset  in  1  asynchronous, active-low reset.
- norm_valid  in  1  element strobe from the normalizer.
- psum_norm_1  in  W_OUT  core-1 normalized element.
- psum_norm_2  in  W_OUT  core-2 normalized element.
- flush  in  1  synchronous clear of the partial row and the FIFO.
- m_valid  out  1  a row pair is available.
- m_ready  in  1  downstream accepts the row pair.
- m_data_1  out  COL*W_OUT  core-1 row; lane k occupies bits [k*W_OUT +: W_OUT].
- m_data_2  out  COL*W_OUT  core-2 row, same packing.
- overflow  out  1  sticky: a completed row was dropped.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): idx=0, assembly registers=0, FIFO empty, m_valid=0, m_data_*=0, overflow=0, level=0.
- Lane mapping: the n-th accepted element of a row (n=0..COL-1) goes to lane n. The first element after reset, flush or a completed row is lane 0.
- Accept: on each edge with norm_valid=1 and flush=0, write both inputs into lane idx of assembly rows 1 and 2, then increment idx.
- Stall tolerance: norm_valid may drop mid-row. idx and partial lanes hold; there is no timeout.
- Row completion: on the edge that accepts idx==COL-1, idx wraps to 0.
  - The complete pair (stored lanes 0..COL-2 plus the incoming lane COL-1 element) is pushed straight into the FIFO on that same edge.
- Latency: m_valid rises the cycle after the last element's norm_valid cycle if the FIFO was empty. There is no combinational path from the inputs to the outputs.
- Output handshake:
  - m_data_* show the FIFO head; they are registered/stable while m_valid=1 and m_ready=0.
  - Pop occurs on an edge with m_valid & m_ready.
  - m_data_* hold their last value when the FIFO is empty.
- Full FIFO:
  - Completion with a simultaneous pop is accepted (level unchanged).
  - Completion without a pop drops the row pair, sets overflow=1 and leaves FIFO contents unchanged. Assembly still restarts at lane 0.
- Empty FIFO: m_ready is ignored and level never underflows.
- Simultaneous push and pop at level 1 or more: level unchanged, ordering preserved.
- flush=1 (priority over everything):
  - idx=0, FIFO emptied, m_valid=0 next cycle, overflow cleared.
  - An input element in the same cycle is discarded.
- Reset mid-row or mid-handshake returns to the reset state immediately. Partial data is lost.
- Data is passed through bit-exact, with no arithmetic.

Optional Feature:
- Macro: NORM_COLLECT_PERF_EN.
- Defined: adds outputs rows_pushed [31:0] and rows_dropped [15:0].
  - Both reset to 0 and are cleared by flush.
  - Each increments by 1 per pushed or dropped row pair and saturates at its maximum value.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Package norm_pkg holds:
  - Defaults COL_DEF=8 and W_OUT_DEF=16.
  - Typedef elem_t = logic [W_OUT-1:0].
  - Typedef row_t = elem_t [COL-1:0].
  - Typedef row_pair_t = struct {row_t r1; row_t r2}.
- One sub-module: norm_row_fifo, a synchronous FIFO of DEPTH entries of row_pair_t.
  - Provides full, empty, level, push, pop and head.
  - Uses the same async active-low reset; flush is its synchronous clear.

Test Plan:
- Basic row: 8 consecutive norm_valid cycles, psum_norm_1=k and psum_norm_2=16'h100+k for k=0..7 → m_valid at cycle 9. m_data_1 lanes 0..7 = 0..7, m_data_2 lanes = 0x100..0x107, level=1.
- Stall mid-row: valid for lanes 0..2, low 5 cycles, then lanes 3..7 → one row with correct lane order, no early m_valid.
- Backpressure and overflow: m_ready=0, push 5 rows with DEPTH=4 → level=4, overflow=1 after the 5th. Then hold m_ready=1 → rows 0..3 drain in order, row 4 is absent.
- Full plus simultaneous pop: FIFO full, m_ready=1 on the completion edge of row 5 → row accepted, level stays 4, overflow stays 0.
- Flush: flush after 3 lanes with 2 rows queued → m_valid=0, level=0. The next 8 elements form a row starting at lane 0.
- Async reset: assert reset mid-row while m_valid=1 → all outputs 0 immediately. After release, a full row produces a correct output. With NORM_COLLECT_PERF_EN defined, rows_pushed and rows_dropped also match the counts from the preceding scenarios.
